// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED decoder: parity-width sizing, Hamming
// position mapping and decode-status encoding.
package hamming_pkg;

  // Decode status of one codeword.
  localparam logic [1:0] ST_CLEAN = 2'd0;  // no error
  localparam logic [1:0] ST_CORR  = 2'd1;  // single error in positions 1..N, flipped
  localparam logic [1:0] ST_PAR   = 2'd2;  // single error in the overall-parity bit
  localparam logic [1:0] ST_DBL   = 2'd3;  // uncorrectable

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int unsigned calc_par_w(input int unsigned data_w);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  // Parity bits live at power-of-two positions.
  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position (1-based) of data bit idx; data fills non-power-of-two slots.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned p = 1; p < 256; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity check of an extended Hamming codeword.
// Ports: code - codeword (bit i-1 = position i, top bit = overall parity)
//        syn  - XOR of the positions of all set bits 1..N
//        par  - XOR of every codeword bit (1 = odd number of flips)
module hamming_syndrome #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned SYN_W  = 3
) (
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn,
  output logic              par
);

  // Syndrome accumulation over Hamming positions 1..N.
  always_comb begin
    syn = '0;
    for (int unsigned i = 1; i < CODE_W; i++) begin
      if (code[i-1]) syn = syn ^ SYN_W'(i);
    end
  end

  assign par = ^code;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready streaming and
// saturating correction / double-error statistics.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_code     - codeword input stream
//        out_valid/out_ready           - result output stream
//        out_data/out_corr/out_dbl/out_err_pos - corrected payload and status
//        cnt_clr                       - synchronous clear of the counters
//        corr_cnt/dbl_cnt              - saturating counts of delivered words
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = calc_par_w(DATA_W),
  localparam int unsigned N      = DATA_W + PAR_W,
  localparam int unsigned CODE_W = N + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_dbl,
  output logic [PAR_W-1:0]  out_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  dbl_cnt
);

  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic              s2_load;
  logic [PAR_W-1:0]  syn;
  logic              par;
  logic [1:0]        status_c;
  logic              flip_c;
  logic [DATA_W-1:0] data_c;

  // Output stage takes a word when empty or draining; stage 1 follows it.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1: capture the raw codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_code <= in_code;
    end
  end

  hamming_syndrome #(
    .CODE_W (CODE_W),
    .SYN_W  (PAR_W)
  ) u_syndrome (
    .code (s1_code),
    .syn  (syn),
    .par  (par)
  );

  // Classify the stage-1 word; syndromes beyond N cannot come from one flip.
  always_comb begin
    status_c = ST_CLEAN;
    if (par) begin
      if (syn == '0)                status_c = ST_PAR;
      else if (syn <= PAR_W'(N))    status_c = ST_CORR;
      else                          status_c = ST_DBL;
    end else if (syn != '0) begin
      status_c = ST_DBL;
    end
  end

  assign flip_c = (status_c == ST_CORR);

  // Extract payload, flipping the data slot the syndrome points at.
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int unsigned POS = data_pos(k);
    assign data_c[k] = s1_code[POS-1] ^ (flip_c && (syn == PAR_W'(POS)));
  end

  // Stage 2: registered decode result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_corr    <= 1'b0;
      out_dbl     <= 1'b0;
      out_err_pos <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= data_c;
        out_corr    <= (status_c == ST_CORR) || (status_c == ST_PAR);
        out_dbl     <= (status_c == ST_DBL);
        out_err_pos <= syn;
      end
    end
  end

  // Saturating statistics, counted on delivery; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      dbl_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      if (out_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_dbl  && (dbl_cnt  != '1)) dbl_cnt  <= dbl_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
Parametrised, pipelined SECDED (extended Hamming) decoder; the successor to the combinational 7-bit Hamming corrector. Accepts one codeword per cycle over a valid/ready stream. Corrects single-bit errors, detects double-bit errors and keeps saturating error statistics. Sits between a link/memory read port and the consumer.

Parameters:
DATA_W, 4, payload bits per codeword (>=1).
CNT_W, 16, width of each error-statistics counter.
Derived: PAR_W = smallest P with 2^P >= DATA_W+P+1 (3 for DATA_W=4, 4 for 8). N = DATA_W+PAR_W. CODE_W = N+1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input codeword valid
in_ready  out  1  decoder can accept
in_code  in  CODE_W  codeword; bit i-1 = Hamming position i (1..N); bit N = overall parity
out_valid  out  1  output valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  corrected payload
out_corr  out  1  single error corrected
out_dbl  out  1  uncorrectable error
out_err_pos  out  PAR_W  syndrome (flipped position; 0 = none or overall-parity bit)
cnt_clr  in  1  synchronous clear of both counters
corr_cnt  out  CNT_W  saturating count of out_corr words delivered
dbl_cnt  out  CNT_W  saturating count of out_dbl words delivered

Behaviour:
- Reset (async, rst_n=0): all valids 0, out_data/out_corr/out_dbl/out_err_pos 0, counters 0. in_ready is 1 after reset. Reset mid-stream discards every in-flight word.
- Encoding: parity at power-of-two positions; data bits fill remaining positions in ascending order (d0 at position 3). Overall parity makes the CODE_W bits XOR to 0.
- Pipeline: stage 1 registers in_code on an input handshake and computes syndrome s (XOR of positions of set bits 1..N) and overall parity p. Stage 2 registers the corrected result. Latency: input handshake in cycle T gives out_valid in cycle T+2 with no backpressure. Throughput 1 word/cycle.
- Handshake: a stage loads when it is empty or its contents move on that cycle. in_ready = !s1_valid || s1 advancing (combinational through the pipeline). With out_ready=0, out_* stay stable and the two stages hold at most 2 words with no loss or duplication.
- Decode rules:
  - s=0, p=0: clean; corr=0, dbl=0.
  - s!=0, p=1, s<=N: flip position s; corr=1; err_pos=s.
  - s=0, p=1: overall-parity bit error; data unchanged; corr=1; err_pos=0.
  - s!=0, p=0: double error; dbl=1; data passed unmodified.
  - s>N, p=1 (unused syndrome): dbl=1.
  - corr and dbl are never both 1.
- Counters: update only on an output handshake (out_valid && out_ready). Each saturates at 2^CNT_W-1 and does not wrap. cnt_clr clears to 0; clear wins over a same-cycle increment.

Decomposition:
- Package hamming_pkg: function computing PAR_W from DATA_W, is_pow2 position function, data-to-position map function, decode-status encoding constants.
- One sub-module, hamming_syndrome (combinational): CODE_W codeword in, s and p out. Reusable by a future encoder check.

Test Plan:
Directed scenarios use DATA_W=4, CODE_W=8, CNT_W=2 unless noted.
1. Reset, then in_code=8'b0000_0001 -> 2 cycles later out_data=4'b0000, out_corr=1, out_err_pos=1, corr_cnt=1 after the handshake.
2. in_code=8'b1001_0111 (data 0001, position 5 flipped) -> out_data=4'b0001, out_corr=1, out_err_pos=5. Clean 8'b1000_0111 -> out_data=4'b0001, corr=0, dbl=0.
3. in_code=8'b1000_0100 (two flips) -> out_dbl=1, out_corr=0, dbl_cnt increments. in_code=8'b0000_0111 -> out_corr=1, out_err_pos=0, out_data=4'b0001.
4. Backpressure: send 3 words back-to-back with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted, out_data holds word 1. After releasing out_ready, the 3 words emerge in order with no gaps.
5. Five correctable words -> corr_cnt saturates at 3. Assert cnt_clr together with a correcting handshake -> corr_cnt=0.
6. Assert rst_n low while 2 words are in flight -> out_valid=0 and counters=0 immediately. No stale word appears after release. Repeat scenario 2 with DATA_W=8 (CODE_W=13), flipping position 12 -> corrected, out_err_pos=12.
